// File: rtl/delay_store.sv
// Programmable-delay sample store: DEPTH-stage shift pipeline with per-stage valid tags,
// a combinational read tap, a maintained occupancy count and a registered drop pulse.
module delay_store #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int TAP_W = ($clog2(DEPTH) > 0) ? $clog2(DEPTH) : 1,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic [TAP_W-1:0] tap,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic [CNT_W-1:0] count,
  output logic             dropped
);

  logic [WIDTH-1:0] stg_data [DEPTH];
  logic [DEPTH-1:0] stg_vld;
  logic [CNT_W-1:0] count_q;
  logic             dropped_q;

  // Shift stages: stage 0 takes the new sample, the oldest falls off the end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stg_data[i] <= '0;
      end
      stg_vld   <= '0;
      count_q   <= '0;
      dropped_q <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        stg_data[i] <= '0;
      end
      stg_vld   <= '0;
      count_q   <= '0;
      dropped_q <= 1'b0;
    end else if (en) begin
      stg_data[0] <= in_data;
      stg_vld[0]  <= in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        stg_data[i] <= stg_data[i-1];
        stg_vld[i]  <= stg_vld[i-1];
      end
      // Entering and leaving valid samples cancel, keeping the count within 0..DEPTH
      count_q   <= count_q + CNT_W'(in_valid) - CNT_W'(stg_vld[DEPTH-1]);
      dropped_q <= stg_vld[DEPTH-1];
    end else begin
      dropped_q <= 1'b0;
    end
  end

  // Read tap: same-cycle mux, out-of-range taps read as an empty stage
  always_comb begin
    out_data  = '0;
    out_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tap == TAP_W'(i)) begin
        out_data  = stg_data[i];
        out_valid = stg_vld[i];
      end
    end
  end

  assign count   = count_q;
  assign dropped = dropped_q;

endmodule

// File: tb/tb_delay_store.sv
// Directed and random bench for delay_store: a reference model pushes the expected
// pipeline image per edge, which is popped and compared against both DUT instances.
module tb_delay_store;

  logic        clk = 1'b0;
  logic        rst, en, flush, in_valid;
  logic [31:0] in_data;
  logic [1:0]  tap4, tap3;
  logic [31:0] od4, od3;
  logic        ov4, ov3, dr4, dr3;
  logic [2:0]  cnt4;
  logic [1:0]  cnt3;

  always #5 clk = ~clk;

  delay_store #(.WIDTH(32), .DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .tap(tap4), .out_data(od4), .out_valid(ov4), .count(cnt4), .dropped(dr4)
  );

  delay_store #(.WIDTH(32), .DEPTH(3)) dut3 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .tap(tap3), .out_data(od3), .out_valid(ov3), .count(cnt3), .dropped(dr3)
  );

  typedef struct packed {
    logic [3:0][31:0] d4;
    logic [3:0]       v4;
    logic             drp4;
    logic [2:0][31:0] d3;
    logic [2:0]       v3;
    logic             drp3;
  } img_t;

  img_t m;
  img_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic img_t model_next(input img_t s, input logic e, input logic f,
                                      input logic v, input logic [31:0] d);
    img_t n = s;
    n.drp4 = 1'b0;
    n.drp3 = 1'b0;
    if (f) begin
      n = '0;
    end else if (e) begin
      n.drp4 = s.v4[3];
      n.drp3 = s.v3[2];
      n.d4 = {s.d4[2], s.d4[1], s.d4[0], d};
      n.v4 = {s.v4[2:0], v};
      n.d3 = {s.d3[1], s.d3[0], d};
      n.v3 = {s.v3[1:0], v};
    end
    return n;
  endfunction

  // Pops one expected image and sweeps every tap of both instances against it.
  task automatic sb_check();
    img_t x;
    if (sbq.size() == 0) begin
      chk("sb_underflow", 64'd1, 64'd0);
      return;
    end
    x = sbq.pop_front();
    chk("cnt4", 64'(cnt4), 64'($countones(x.v4)));
    chk("drop4", 64'(dr4), 64'(x.drp4));
    chk("cnt3", 64'(cnt3), 64'($countones(x.v3)));
    chk("drop3", 64'(dr3), 64'(x.drp3));
    for (int t = 0; t < 4; t++) begin
      tap4 = 2'(t);
      tap3 = 2'(t);
      #1;
      chk("data4", 64'(od4), 64'(x.d4[t]));
      chk("vld4", 64'(ov4), 64'(x.v4[t]));
      chk("data3", 64'(od3), (t < 3) ? 64'(x.d3[t]) : 64'd0);
      chk("vld3", 64'(ov3), (t < 3) ? 64'(x.v3[t]) : 64'd0);
    end
    tap4 = 2'd0;
    tap3 = 2'd0;
  endtask

  task automatic step(input logic e, input logic f, input logic v, input logic [31:0] d);
    en = e; flush = f; in_valid = v; in_data = d;
    m = model_next(m, e, f, v, d);
    sbq.push_back(m);
    @(posedge clk);
    #1;
    sb_check();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    tap4 = 2'd0; tap3 = 2'd0;
    m = '0;
    // Async reset visible before the first clock edge
    #2;
    chk("rst_cnt", 64'(cnt4), 64'd0);
    chk("rst_drop", 64'(dr4), 64'd0);
    chk("rst_vld", 64'(ov4), 64'd0);
    chk("rst_data", 64'(od4), 64'd0);
    #5 rst = 1'b0;

    // Shift 5,1,8,9
    step(1, 0, 1, 32'd5);
    step(1, 0, 1, 32'd1);
    step(1, 0, 1, 32'd8);
    step(1, 0, 1, 32'd9);
    tap4 = 2'd0; #1 chk("shift_tap0", 64'(od4), 64'd9);
    tap4 = 2'd3; #1 chk("shift_tap3", 64'(od4), 64'd5);
    chk("shift_cnt", 64'(cnt4), 64'd4);
    chk("shift_drop", 64'(dr4), 64'd0);

    // Overflow: one-cycle drop pulse, count saturates naturally at DEPTH
    step(1, 0, 1, 32'd7);
    tap4 = 2'd3; #1 chk("ovf_tap3", 64'(od4), 64'd1);
    chk("ovf_cnt", 64'(cnt4), 64'd4);
    chk("ovf_drop", 64'(dr4), 64'd1);

    // Hold, then a bubble
    for (int i = 0; i < 5; i++) step(0, 0, 1, 32'hDEAD);
    chk("hold_drop", 64'(dr4), 64'd0);
    chk("hold_cnt", 64'(cnt4), 64'd4);
    tap4 = 2'd3; #1 chk("hold_tap3", 64'(od4), 64'd1);
    step(1, 0, 0, 32'h55);
    chk("bubble_cnt", 64'(cnt4), 64'd3);
    tap4 = 2'd0; #1 chk("bubble_vld0", 64'(ov4), 64'd0);

    // Flush wins over en; 3 never captured
    step(1, 1, 1, 32'd3);
    chk("flush_cnt", 64'(cnt4), 64'd0);
    step(0, 0, 0, 32'd0);
    step(0, 0, 0, 32'd0);

    // Tap out of range on DEPTH=3 with a non-empty pipe
    step(1, 0, 1, 32'hA5A5);
    tap3 = 2'd3; #1;
    chk("oor_data3", 64'(od3), 64'd0);
    chk("oor_vld3", 64'(ov3), 64'd0);
    tap3 = 2'd0;

    // Mid-cycle reset with a full pipe and a pending drop pulse
    for (int i = 0; i < 5; i++) step(1, 0, 1, 32'(100 + i));
    chk("pre_rst_drop", 64'(dr4), 64'd1);
    rst = 1'b1;
    #1;
    chk("mrst_cnt", 64'(cnt4), 64'd0);
    chk("mrst_drop", 64'(dr4), 64'd0);
    chk("mrst_vld0", 64'(ov4), 64'd0);
    chk("mrst_data0", 64'(od4), 64'd0);
    tap4 = 2'd3; #1;
    chk("mrst_data3", 64'(od4), 64'd0);
    chk("mrst_cnt3", 64'(cnt3), 64'd0);
    #1 rst = 1'b0;
    tap4 = 2'd0;
    m = '0;

    // Random traffic, every cycle checked against the model
    for (int i = 0; i < 1000; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 1)), $urandom);
    end

    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
